// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// default line settings and the bit-period helper.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int unsigned DEF_CLK_FREQ_HZ = 32'd100_000_000;
    localparam int unsigned DEF_BAUD        = 32'd115_200;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; the reset value
// is a parameter so an idle-high line does not look like a start bit.
module uart_rx_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop framing with mid-bit sampling, single-entry
// output register on a valid/ready port, frame-error and overrun pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int unsigned BAUD        = DEF_BAUD,
    parameter int unsigned DATA_BITS   = 32'd8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_err_o,
    output logic                 busy_o
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 32'd2 - 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 32'd1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 32'd1);

    generate
        if (CLKS_PER_BIT < 32'd4) begin : g_bad_cpb
            $error("uart_rx: CLK_FREQ_HZ/BAUD must be at least 4");
        end
        if (DATA_BITS < 32'd5 || DATA_BITS > 32'd9) begin : g_bad_bits
            $error("uart_rx: DATA_BITS must be within 5..9");
        end
    endgenerate

    logic                 rx_s;
    logic                 frame_good_s;
    logic                 accept_s;

    rx_state_e            state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 valid_q,   valid_d;
    logic                 ferr_q,    ferr_d;
    logic                 ovr_q,     ovr_d;
    logic                 busy_q,    busy_d;

    uart_rx_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    // Frame sequencing: baud counter, bit index and shift register.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        frame_good_s = 1'b0;
        ferr_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = CNT_ZERO;
                    bit_idx_d = IDX_ZERO;
                    // A start bit that is gone by mid-bit was a glitch.
                    if (!rx_s) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d            = CNT_ZERO;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                    if (rx_s) begin
                        frame_good_s = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output register: a completing frame may reuse the slot being handed off this cycle.
    always_comb begin
        accept_s = valid_q & rx_ready_i;
        data_d   = data_q;
        ovr_d    = 1'b0;
        if (accept_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (frame_good_s) begin
            if (!valid_q || accept_s) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else begin
            data_d = data_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            bit_idx_q <= IDX_ZERO;
            shift_q   <= {DATA_BITS{1'b0}};
            data_q    <= {DATA_BITS{1'b0}};
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_data_o     = data_q;
    assign rx_valid_o    = valid_q;
    assign frame_err_o   = ferr_q;
    assign overrun_err_o = ovr_q;
    assign busy_o        = busy_q;

endmodule
